// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter: response owner encoding,
// access-size codes and the alignment rule for data-side accesses.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IF     = 2'd1,
    OWN_DM     = 2'd2,
    OWN_DM_ERR = 2'd3
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size code 2'b11 is reserved and behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size == SZ_BYTE) return 1'b0;
    if (size == SZ_HALF) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/bram_lane_align.sv
// Byte-lane steering between the core and a 32-bit little-endian BRAM word:
// store byte-enable/replication on one side, load right-shift and mask on the other.
module bram_lane_align
  import bram_arb_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_data,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_data,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  always_comb begin
    o_st_be   = 4'b1111;
    o_st_data = i_st_data;
    case (i_st_size)
      SZ_BYTE: begin
        o_st_be   = 4'b0001 << i_st_off;
        o_st_data = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_st_be   = 4'b0011 << {i_st_off[1], 1'b0};
        o_st_data = {2{i_st_data[15:0]}};
      end
      default: begin
      end
    endcase
  end

  // Sign extension is the core's job; unused upper bits come back as zero.
  always_comb begin
    w_shifted = i_ld_data >> {i_ld_off, 3'b000};
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {24'h0, w_shifted[7:0]};
      SZ_HALF: o_ld_data = {16'h0, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port synchronous-read BRAM between fetch (IF) and data (DM);
// DM has priority, IF is guaranteed a slot after MAX_DM_STREAK consecutive DM wins.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_owner
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  // Handshake: a requester holds req and its address/data until it sees gnt in
  // the same cycle; gnt=1 consumes the request, so a new one may be presented
  // in that very cycle. Stall = req & ~gnt. Exactly one response pulse
  // (rvalid) follows each grant one cycle later, unless discarded by reset or
  // (fetch only) by if_kill.

  logic [3:0]  r_streak;
  owner_e      r_owner;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_store;
  logic        r_kill;

  logic        w_if_gnt;
  logic        w_dm_gnt;
  logic        w_dm_mis;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;
  logic        w_unused_bits;

  assign w_if_gnt = reset & if_req & (~dm_req | (r_streak == STREAK_MAX));
  assign w_dm_gnt = reset & dm_req & ~w_if_gnt;
  assign w_dm_mis = misaligned(dm_size, dm_addr[1:0]);

  assign if_gnt = w_if_gnt;
  assign dm_gnt = w_dm_gnt;

  bram_lane_align u_lane (
    .i_st_size (dm_size),
    .i_st_off  (dm_addr[1:0]),
    .i_st_data (dm_wdata),
    .o_st_be   (w_st_be),
    .o_st_data (w_st_data),
    .i_ld_size (r_size),
    .i_ld_off  (r_off),
    .i_ld_data (mem_rdata),
    .o_ld_data (w_ld_data)
  );

  // A misaligned DM access is granted (so the core unstalls) but never reaches the BRAM.
  assign mem_en    = w_if_gnt | (w_dm_gnt & ~w_dm_mis);
  assign mem_we    = (w_dm_gnt & dm_we & ~w_dm_mis) ? w_st_be : 4'b0000;
  assign mem_addr  = w_if_gnt ? if_addr[ADDR_W+1:2] : dm_addr[ADDR_W+1:2];
  assign mem_wdata = w_st_data;

  assign w_unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], dm_addr[31:ADDR_W+2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
      r_owner  <= OWN_NONE;
      r_off    <= '0;
      r_size   <= '0;
      r_store  <= 1'b0;
      r_kill   <= 1'b0;
    end else begin
      if (!if_req || w_if_gnt)
        r_streak <= '0;
      else if (w_dm_gnt && r_streak != STREAK_MAX)
        r_streak <= r_streak + 4'd1;

      if (w_if_gnt) begin
        r_owner <= OWN_IF;
        r_kill  <= if_kill;
      end else if (w_dm_gnt) begin
        r_owner <= w_dm_mis ? OWN_DM_ERR : OWN_DM;
        r_off   <= dm_addr[1:0];
        r_size  <= dm_size;
        r_store <= dm_we;
        r_kill  <= 1'b0;
      end else begin
        r_owner <= OWN_NONE;
        r_kill  <= 1'b0;
      end
    end
  end

  // A kill seen either when the fetch was granted or during its response drops it.
  assign if_rvalid = (r_owner == OWN_IF) & ~r_kill & ~if_kill;
  assign if_rdata  = (r_owner == OWN_IF) ? mem_rdata : 32'h0;
  assign dm_rvalid = (r_owner == OWN_DM) | (r_owner == OWN_DM_ERR);
  assign dm_err    = (r_owner == OWN_DM_ERR);
  assign dm_rdata  = (r_owner == OWN_DM && !r_store) ? w_ld_data : 32'h0;
  assign dbg_owner = r_owner;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, byte-level reference memory and
// arbitration model, table-driven store vectors, directed corners and random traffic.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int ADDR_W        = 12;
  localparam int MAX_DM_STREAK = 4;
  localparam int WORDS         = 1 << ADDR_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_kill, if_gnt, if_rvalid;
  logic [31:0]       if_addr, if_rdata;
  logic              dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
  logic [1:0]        dm_size;
  logic [31:0]       dm_addr, dm_wdata, dm_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;
  logic [1:0]        dbg_owner;

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DM_STREAK(MAX_DM_STREAK)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_owner(dbg_owner)
  );

  function automatic logic [31:0] pattern(input int i);
    return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h0F0F_0F0F;
  endfunction

  // Synchronous-read, read-first single-port BRAM.
  logic [31:0] bram [WORDS];
  logic        bram_ready = 1'b0;
  always @(posedge clk) begin
    if (!bram_ready) begin
      for (int i = 0; i < WORDS; i++) bram[i] <= pattern(i);
      bram_ready <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= bram[mem_addr];
      for (int k = 0; k < 4; k++)
        if (mem_we[k]) bram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_bytes [4*WORDS];
  logic [34:0] exp_q[$];          // {if_valid, dm_valid, dm_err, data}
  int          dm_run;
  int          n_vec = 0;
  int          n_err = 0;
  logic        g_if = 1'b0;
  logic        g_dm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_read(input int ba, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_bytes[ba + k];
    return v;
  endfunction

  // Called #1 after the driving negedge: checks last cycle's response, this
  // cycle's grant and BRAM control, then advances the model.
  task automatic check_cycle();
    logic [34:0] e;
    logic        exp_if_g, exp_dm_g, mis;
    logic [3:0]  exp_we;
    logic [31:0] wmask, exp_wd;
    int          n, ba, lane;
    #1;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("if_rvalid", 32'(if_rvalid), 32'(e[34] & ~if_kill));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(e[33]));
    chk("dm_err", 32'(dm_err), 32'(e[32]));
    if (e[34] && !if_kill) chk("if_rdata", if_rdata, e[31:0]);
    if (e[33]) chk("dm_rdata", dm_rdata, e[31:0]);

    exp_if_g = if_req & (!dm_req | (dm_run == MAX_DM_STREAK));
    exp_dm_g = dm_req & !exp_if_g;
    chk("grant", {30'd0, if_gnt, dm_gnt}, {30'd0, exp_if_g, exp_dm_g});

    n   = size_bytes(dm_size);
    ba  = int'(dm_addr[ADDR_W+1:0]);
    mis = (ba % n) != 0;
    exp_we = '0;
    wmask  = '0;
    exp_wd = '0;
    if (exp_dm_g && dm_we && !mis)
      for (int k = 0; k < n; k++) begin
        lane = (ba % 4) + k;
        exp_we[lane] = 1'b1;
        wmask[8*lane +: 8]  = 8'hFF;
        exp_wd[8*lane +: 8] = dm_wdata[8*k +: 8];
      end
    chk("mem_en", 32'(mem_en), 32'(exp_if_g | (exp_dm_g & !mis)));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("mem_wdata_lanes", mem_wdata & wmask, exp_wd);
    if (exp_if_g) chk("mem_addr_if", 32'(mem_addr), 32'(if_addr[ADDR_W+1:2]));
    else if (exp_dm_g && !mis) chk("mem_addr_dm", 32'(mem_addr), 32'(dm_addr[ADDR_W+1:2]));

    if (exp_if_g) begin
      exp_q.push_back({~if_kill, 2'b00, ref_read(4 * int'(if_addr[ADDR_W+1:2]), 4)});
    end else if (exp_dm_g) begin
      if (mis) exp_q.push_back({3'b011, 32'h0});
      else if (dm_we) begin
        for (int k = 0; k < n; k++) ref_bytes[ba + k] = dm_wdata[8*k +: 8];
        exp_q.push_back({3'b010, 32'h0});
      end else exp_q.push_back({3'b010, ref_read(ba, n)});
    end else exp_q.push_back('0);

    if (!if_req || exp_if_g) dm_run = 0;
    else if (exp_dm_g && dm_run < MAX_DM_STREAK) dm_run++;
    g_if = if_gnt;
    g_dm = dm_gnt;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = SZ_WORD; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic drive_dm(input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    dm_req = 1'b1; dm_we = we; dm_size = size; dm_addr = addr; dm_wdata = wdata;
  endtask

  task automatic drive_if(input logic [31:0] addr);
    if_req = 1'b1; if_addr = addr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    exp_q.delete();
    dm_run = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_cycle();
  endtask

  task automatic idle_cycle();
    @(negedge clk); idle_inputs(); check_cycle();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [1:0]  size;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic        en;
    logic [3:0]  we;
    logic [31:0] wd;
  } st_vec_t;

  st_vec_t     vt[8];
  logic [9:0]  pat_if;
  logic [31:0] w64;

  initial begin
    vt[0] = '{SZ_BYTE, 2'd3, 32'h0000_00AB, 1'b1, 4'b1000, 32'hABAB_ABAB};
    vt[1] = '{SZ_BYTE, 2'd0, 32'h7777_7712, 1'b1, 4'b0001, 32'h1212_1212};
    vt[2] = '{SZ_HALF, 2'd2, 32'h0000_BEEF, 1'b1, 4'b1100, 32'hBEEF_BEEF};
    vt[3] = '{SZ_HALF, 2'd0, 32'h0000_1234, 1'b1, 4'b0011, 32'h1234_1234};
    vt[4] = '{SZ_WORD, 2'd0, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF};
    vt[5] = '{2'b11,   2'd0, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'hCAFE_F00D};
    vt[6] = '{SZ_HALF, 2'd1, 32'h0000_5555, 1'b0, 4'b0000, 32'h0};
    vt[7] = '{SZ_WORD, 2'd2, 32'h6666_6666, 1'b0, 4'b0000, 32'h0};

    for (int i = 0; i < WORDS; i++) begin
      w64 = pattern(i);
      for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w64[8*k +: 8];
    end
    dm_run = 0;

    // Reset state with both requests asserted.
    reset = 1'b0;
    idle_inputs();
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
    #3;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalids", {29'd0, if_rvalid, dm_rvalid, dm_err}, 32'd0);
    chk("rst_owner", 32'(dbg_owner), 32'd0);
    do_reset();

    // Fetch stream 0,4,8.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_inputs();
      if (i < 3) drive_if(32'(4 * i));
      check_cycle();
      if (i < 3) chk("t1_if_gnt", 32'(if_gnt), 32'd1);
      if (i > 0) begin
        chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("t1_if_rdata", if_rdata, pattern(i - 1));
      end
    end

    // Contention: both requesting for 10 cycles.
    idle_cycle();
    pat_if = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle_inputs();
      drive_if(32'h10);
      drive_dm(1'b0, SZ_WORD, 32'h20, 32'h0);
      check_cycle();
      chk("t2_if_gnt", 32'(if_gnt), 32'(pat_if[i]));
      chk("t2_dm_gnt", 32'(dm_gnt), 32'(!pat_if[i]));
    end
    idle_cycle();

    // Byte store to 0x103, then word load from 0x100.
    @(negedge clk); idle_inputs(); drive_dm(1'b1, SZ_BYTE, 32'h103, 32'h0000_00AB); check_cycle();
    chk("t3_mem_we", 32'(mem_we), 32'h8);
    chk("t3_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    @(negedge clk); idle_inputs(); drive_dm(1'b0, SZ_WORD, 32'h100, 32'h0); check_cycle();
    chk("t3_store_ack", {31'd0, dm_rvalid}, 32'd1);
    idle_cycle();
    w64 = pattern(64);
    chk("t3_load", dm_rdata, {8'hAB, w64[23:0]});

    // Half load from 0x102 of 0x87654321.
    @(negedge clk); idle_inputs(); drive_dm(1'b1, SZ_WORD, 32'h100, 32'h8765_4321); check_cycle();
    @(negedge clk); idle_inputs(); drive_dm(1'b0, SZ_HALF, 32'h102, 32'h0); check_cycle();
    idle_cycle();
    chk("t4_half", dm_rdata, 32'h0000_8765);
    chk("t4_err", 32'(dm_err), 32'd0);

    // Misaligned word store to 0x101.
    @(negedge clk); idle_inputs(); drive_dm(1'b1, SZ_WORD, 32'h101, 32'hFFFF_FFFF); check_cycle();
    chk("t5_gnt", 32'(dm_gnt), 32'd1);
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    chk("t5_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk); idle_inputs(); drive_dm(1'b0, SZ_WORD, 32'h100, 32'h0); check_cycle();
    chk("t5_err_resp", {29'd0, dm_rvalid, dm_err, 1'b0}, 32'h6);
    chk("t5_err_data", dm_rdata, 32'h0);
    idle_cycle();
    chk("t5_unchanged", dm_rdata, 32'h8765_4321);

    // Store lane table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle_inputs();
      drive_dm(1'b1, vt[i].size, 32'h200 + 32'(vt[i].off), vt[i].wdata);
      check_cycle();
      chk("tbl_mem_en", 32'(mem_en), 32'(vt[i].en));
      chk("tbl_mem_we", 32'(mem_we), 32'(vt[i].we));
      if (vt[i].en) chk("tbl_mem_wdata", mem_wdata, vt[i].wd);
      @(negedge clk); idle_inputs(); drive_dm(1'b0, SZ_WORD, 32'h200, 32'h0); check_cycle();
    end
    idle_cycle();

    // Kill in response cycle, then kill in grant cycle.
    @(negedge clk); idle_inputs(); drive_if(32'h0); check_cycle();
    @(negedge clk); idle_inputs(); if_kill = 1'b1; check_cycle();
    chk("t6_kill_resp", 32'(if_rvalid), 32'd0);
    @(negedge clk); idle_inputs(); drive_if(32'h4); if_kill = 1'b1; check_cycle();
    idle_cycle();
    chk("t6_kill_grant", 32'(if_rvalid), 32'd0);

    // Reset in the response cycle of a DM load.
    @(negedge clk); idle_inputs(); drive_dm(1'b0, SZ_WORD, 32'h100, 32'h0); check_cycle();
    @(negedge clk); idle_inputs(); reset = 1'b0; exp_q.delete(); dm_run = 0;
    #1;
    chk("t6_rst_outs", {26'd0, if_rvalid, dm_rvalid, dm_err, mem_en, if_gnt, dm_gnt}, 32'd0);
    chk("t6_rst_rdata", dm_rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_cycle();
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("t6_no_rvalid", 32'(dm_rvalid), 32'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!if_req || g_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'h100 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3))
                  + (32'($urandom_range(0, 255)) << 24);
      end
      if (!dm_req || g_dm) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = 1'($urandom_range(0, 1));
        dm_size  = 2'($urandom_range(0, 3));
        dm_addr  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 255)) << 24);
        dm_wdata = $urandom();
      end
      if_kill = ($urandom_range(0, 7) == 0);
      check_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port, synchronous-read BRAM between the pipelined core's fetch stage (IF) and memory stage (DM).
- Grants at most one access per cycle and returns read data one cycle after the grant.
- Generates BRAM byte-write enables from the access size, and gives the hazard unit per-requester grants for stalling.
- Data side has priority, with a starvation guard for fetch.

Parameters:
ADDR_W, 12, BRAM word-address width (byte address bits [ADDR_W+1:2] are used).
MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is waiting, after which IF wins one cycle (range 1..15).

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request
if_addr  in  32  fetch byte address (word aligned; bits [1:0] ignored)
if_kill  in  1  drop the in-flight fetch response (branch flush)
if_gnt  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  fetch data valid (one cycle after grant)
if_rdata  out  32  fetch instruction word
dm_req  in  1  data request (load or store)
dm_we  in  1  1 = store
dm_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
dm_addr  in  32  data byte address
dm_wdata  in  32  store data, right-aligned
dm_gnt  out  1  data granted this cycle (combinational)
dm_rvalid  out  1  load data valid / store acknowledge (one cycle after grant)
dm_rdata  out  32  load data shifted right to bit 0, upper bits zero (the core does sign extension)
dm_err  out  1  misaligned access; pulses together with dm_rvalid
mem_en  out  1  BRAM enable
mem_we  out  4  BRAM byte write enables
mem_addr  out  ADDR_W  BRAM word address
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  BRAM read data (valid the cycle after mem_en)

Behaviour:
- Reset (reset=0, asynchronous): streak counter = 0; response owner = NONE; all rvalid, err and gnt outputs = 0; mem_en = 0, mem_we = 0.
- Grant, evaluated combinationally each cycle:
  - dm_req only -> DM.
  - if_req only -> IF.
  - Both -> DM, unless streak == MAX_DM_STREAK, in which case IF.
  - Exactly one of if_gnt/dm_gnt is 1 when any request is present; both are 0 when idle.
- Streak counter:
  - Increments on each DM grant while if_req=1, saturating at MAX_DM_STREAK.
  - Clears on any IF grant, and on any cycle where if_req=0.
- Handshake: a requester holds req/addr/data stable until gnt. In the cycle gnt=1 it may present the next request, so back-to-back accesses at 1 per cycle are allowed. Core stall = req & ~gnt.
- Granted cycle:
  - mem_en=1; mem_addr = addr[ADDR_W+1:2].
  - Store, byte: mem_we = 0001 << addr[1:0]; mem_wdata = byte replicated x4.
  - Store, half: mem_we = 0011 << {addr[1],0}; mem_wdata = halfword replicated x2.
  - Store, word: mem_we = 1111.
  - Loads and fetches: mem_we = 0000.
- Misaligned DM access (half with addr[0]=1, or word with addr[1:0]!=0): still granted, but mem_en=0 and mem_we=0 (no write). Next cycle: dm_rvalid=1, dm_err=1, dm_rdata=0.
- Response-owner FSM, states NONE / IF / DM / DM_ERR:
  - Next state = owner of this cycle's grant (DM_ERR if misaligned), or NONE if there was no grant.
  - The FSM registers byte offset and size for the DM load path.
- Response cycle (state IF or DM):
  - if_rdata = mem_rdata.
  - dm_rdata = mem_rdata >> (8*offset), masked to the access size.
  - Store response: dm_rvalid=1, dm_rdata=0.
- if_kill=1 in the response cycle, or in the grant cycle (registered), forces if_rvalid=0 for that fetch. A kill never affects DM responses.
- Simultaneous response and new grant are normal (pipelined); the FSM advances every cycle.
- Reset mid-access: the pending response is discarded, with no rvalid after reset release.
- rvalid outputs are single-cycle pulses. if_rvalid and dm_rvalid are never 1 together.

Decomposition:
- Package bram_arb_pkg:
  - owner_e enum (NONE, IF, DM, DM_ERR).
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - function misaligned(size, off).
- One sub-module, bram_lane_align: combinational store lane replicate / byte-enable generation, plus load right-shift and mask. Reused on both paths.

Test Plan:
1. Fetch stream only: if_req=1 with addresses 0,4,8 on consecutive cycles -> if_gnt=1 every cycle; if_rvalid on cycles 2-4 with BRAM words 0-2.
2. Contention with MAX_DM_STREAK=4: if_req and dm_req held high for 10 cycles -> grant pattern DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
3. Byte store of 0x000000AB to address 0x103 -> mem_we=1000, mem_wdata=0xABABABAB. Then a word load from 0x100 returns 0xAB<<24 | old[23:0].
4. Half load from 0x102 where the word is 0x8765_4321 -> dm_rdata=0x0000_8765, dm_err=0.
5. Word store to 0x101 -> mem_we=0000 and mem_en=0 in the grant cycle; next cycle dm_rvalid=1, dm_err=1; memory unchanged.
6. if_kill=1 in a fetch response cycle -> if_rvalid=0. Separately, reset=0 in the cycle after a DM grant -> no dm_rvalid after reset release, and all outputs 0.
